// File: rtl/uart_ring_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_ring_pkg : shared FSM state encoding and dump-mode constants         |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package uart_ring_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WAIT = 3'd2,
    S_SEND = 3'd3,
    S_WTX  = 3'd4
  } state_t;

  localparam logic MODE_DRAIN  = 1'b0;
  localparam logic MODE_REPLAY = 1'b1;

endpackage
`default_nettype wire

// File: rtl/uart_ring_ram.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_ring_ram : simple dual-port RAM, one write port, registered read    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module uart_ring_ram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              i_clk,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);

  localparam int c_depth = 1 << ADDR_W;

  // No reset on the array or read register so the tools can map this to block RAM.
  logic [DATA_W-1:0] r_mem [0:c_depth-1];

  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
    o_rd_data <= r_mem[i_rd_addr];
  end

endmodule
`default_nettype wire

// File: rtl/uart_ring_dump_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_ring_dump_ctrl : ring-buffered UART store-and-dump controller       |
// | Optional macro UART_RING_DROP_CNT_EN adds the Drop_cnt output.           |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module uart_ring_dump_ctrl
  import uart_ring_pkg::*;
#(
  parameter int   DATA_W    = 8,
  parameter int   ADDR_W    = 8,
  parameter logic KEY_PRESS = 1'b0
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Rx_done,
  input  logic [DATA_W-1:0] Rx_byte,
  input  logic              Key_flag,
  input  logic              Key_state,
  input  logic              Mode,
  input  logic              Tx_done,
  output logic              Tx_en,
  output logic [DATA_W-1:0] Tx_data,
  output logic              Busy,
  output logic              Empty,
  output logic              Full,
  output logic [ADDR_W:0]   Count,
`ifdef UART_RING_DROP_CNT_EN
  output logic              Overflow,
  output logic [15:0]       Drop_cnt
`else
  output logic              Overflow
`endif
);

  localparam logic [ADDR_W:0] c_depth = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] c_one   = {{ADDR_W{1'b0}}, 1'b1};

  state_t              r_state;
  state_t              w_next_state;
  logic [ADDR_W:0]     r_wr_ptr;
  logic [ADDR_W:0]     r_rd_ptr;
  logic [ADDR_W:0]     r_remain;
  logic [ADDR_W:0]     w_count;
  logic [ADDR_W-1:0]   r_scan_ptr;
  logic                r_mode;
  logic                r_overflow;
  logic [DATA_W-1:0]   r_tx_data;
  logic [DATA_W-1:0]   w_q;
  logic                w_full;
  logic                w_wr_en;
  logic                w_drop;
  logic                w_start;
  logic                w_pop;

  assign w_count = r_wr_ptr - r_rd_ptr;
  assign w_full  = (w_count == c_depth);
  assign w_wr_en = Rx_done && !w_full;
  assign w_drop  = Rx_done && w_full;
  assign w_start = (r_state == S_IDLE) && Key_flag && (Key_state == KEY_PRESS);
  assign w_pop   = (r_state == S_WTX) && Tx_done;

  uart_ring_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .i_clk     (Clk),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (r_wr_ptr[ADDR_W-1:0]),
    .i_wr_data (Rx_byte),
    .i_rd_addr (r_scan_ptr),
    .o_rd_data (w_q)
  );

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    Tx_en        = 1'b0;
    case (r_state)
      S_IDLE: if (w_start && (w_count != '0)) w_next_state = S_RD;
      S_RD:   w_next_state = S_WAIT;
      S_WAIT: w_next_state = S_SEND;
      S_SEND: begin
        Tx_en        = 1'b1;
        w_next_state = S_WTX;
      end
      S_WTX:  if (Tx_done) w_next_state = (r_remain != c_one) ? S_RD : S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_scan_ptr <= '0;
      r_remain   <= '0;
      r_mode     <= MODE_DRAIN;
      r_overflow <= 1'b0;
      r_tx_data  <= '0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + c_one;
      end
      if (w_start) begin
        r_mode     <= Mode;
        r_scan_ptr <= r_rd_ptr[ADDR_W-1:0];
        r_remain   <= w_count;
      end else if (w_pop) begin
        r_scan_ptr <= r_scan_ptr + ADDR_W'(1);
        r_remain   <= r_remain - c_one;
        if (r_mode == MODE_DRAIN) begin
          r_rd_ptr <= r_rd_ptr + c_one;
        end
      end
      // Loaded one cycle early so the byte is already valid while Tx_en is high.
      if (r_state == S_WAIT) begin
        r_tx_data <= w_q;
      end
      // A byte dropped in the dump-start cycle still gets reported.
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (w_start) begin
        r_overflow <= 1'b0;
      end
    end
  end

`ifdef UART_RING_DROP_CNT_EN
  logic [15:0] r_drop_cnt;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_drop_cnt <= '0;
    end else if (w_start) begin
      r_drop_cnt <= w_drop ? 16'd1 : 16'd0;
    end else if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
      r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  assign Drop_cnt = r_drop_cnt;
`endif

  assign Tx_data  = r_tx_data;
  assign Busy     = (r_state != S_IDLE);
  assign Empty    = (w_count == '0);
  assign Full     = w_full;
  assign Count    = w_count;
  assign Overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_uart_ring_dump_ctrl.sv
`default_nettype none
// Bench for uart_ring_dump_ctrl: queue-based reference model, per-cycle compare,
// plus directed scenarios with literal expectations.
module tb_uart_ring_dump_ctrl;

  localparam int   DATA_W    = 8;
  localparam int   ADDR_W    = 2;
  localparam int   DEPTH     = 4;
  localparam logic KEY_PRESS = 1'b0;

  logic              Clk       = 1'b0;
  logic              Rst       = 1'b1;
  logic              Rx_done   = 1'b0;
  logic [DATA_W-1:0] Rx_byte   = '0;
  logic              Key_flag  = 1'b0;
  logic              Key_state = ~KEY_PRESS;
  logic              Mode      = 1'b0;
  logic              Tx_done   = 1'b0;
  logic              Tx_en;
  logic [DATA_W-1:0] Tx_data;
  logic              Busy;
  logic              Empty;
  logic              Full;
  logic [ADDR_W:0]   Count;
  logic              Overflow;
`ifdef UART_RING_DROP_CNT_EN
  logic [15:0]       Drop_cnt;
`endif

  uart_ring_dump_ctrl #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .KEY_PRESS (KEY_PRESS)
  ) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .Rx_done   (Rx_done),
    .Rx_byte   (Rx_byte),
    .Key_flag  (Key_flag),
    .Key_state (Key_state),
    .Mode      (Mode),
    .Tx_done   (Tx_done),
    .Tx_en     (Tx_en),
    .Tx_data   (Tx_data),
    .Busy      (Busy),
    .Empty     (Empty),
    .Full      (Full),
    .Count     (Count),
`ifdef UART_RING_DROP_CNT_EN
    .Overflow  (Overflow),
    .Drop_cnt  (Drop_cnt)
`else
    .Overflow  (Overflow)
`endif
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: timed out waiting for DUT (t=%0t)", name, $time);
  endtask

  // ---------------- reference model ----------------
  // Buffer is a queue of stored bytes; a dump sends a snapshot copy. Tx_en is due
  // 3 cycles after the start cycle or after the accepted Tx_done cycle.
  int         cyc = 0;
  logic [7:0] m_buf[$];
  logic [7:0] m_snap[$];
  bit         m_busy, m_mode, m_await, m_ovf;
  int         m_idx, m_left, m_due, m_drop;

  always @(posedge Clk) begin : p_model
    bit full;
    cyc++;
    if (Rst) begin
      m_buf.delete();
      m_busy = 0; m_await = 0; m_ovf = 0; m_drop = 0;
      m_idx = 0; m_left = 0; m_due = -10;
    end else begin
      full = (m_buf.size() == DEPTH);
      if (!m_busy && Key_flag && (Key_state == KEY_PRESS)) begin
        m_ovf  = 0;
        m_drop = 0;
        if (m_buf.size() != 0) begin
          m_busy = 1; m_mode = Mode; m_snap = m_buf;
          m_idx = 0; m_left = m_buf.size(); m_due = cyc + 2; m_await = 0;
        end
      end else if (m_busy && m_await && Tx_done) begin
        if (!m_mode) void'(m_buf.pop_front());
        m_idx++; m_left--; m_await = 0;
        if (m_left == 0) m_busy = 0;
        else m_due = cyc + 2;
      end
      if (m_busy && !m_await && (cyc - 1 == m_due)) m_await = 1;
      if (Rx_done) begin
        if (!full) m_buf.push_back(Rx_byte);
        else begin
          m_ovf = 1;
          if (m_drop != 65535) m_drop++;
        end
      end
    end
  end

  logic [7:0] tx_log[$];
  int         tx_cyc[$];

  always @(negedge Clk) begin : p_compare
    if (!Rst) begin
      check("count", 32'(Count), 32'(m_buf.size()));
      check("empty", 32'(Empty), 32'(m_buf.size() == 0));
      check("full", 32'(Full), 32'(m_buf.size() == DEPTH));
      check("overflow", 32'(Overflow), 32'(m_ovf));
      check("busy", 32'(Busy), 32'(m_busy));
      check("tx_en", 32'(Tx_en), 32'(m_busy && !m_await && (cyc == m_due)));
`ifdef UART_RING_DROP_CNT_EN
      check("drop_cnt", 32'(Drop_cnt), 32'(m_drop));
`endif
      if (Tx_en === 1'b1) begin
        tx_log.push_back(Tx_data);
        tx_cyc.push_back(cyc);
      end
      if (m_busy && (m_await || Tx_en === 1'b1))
        check("tx_data", 32'(Tx_data), 32'(m_snap[m_idx]));
    end
  end

  // UART transmitter stand-in: Tx_done 4 cycles after each Tx_en.
  initial begin : p_uart
    forever begin
      @(negedge Clk);
      if (Tx_en === 1'b1) begin
        repeat (4) @(posedge Clk);
        #1 Tx_done = 1'b1;
        @(posedge Clk);
        #1 Tx_done = 1'b0;
      end
    end
  end

  initial begin : p_watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic rx(input logic [7:0] b);
    Rx_byte = b;
    Rx_done = 1'b1;
    tick();
    Rx_done = 1'b0;
  endtask

  task automatic key(input logic m, output int s);
    Mode      = m;
    Key_flag  = 1'b1;
    Key_state = KEY_PRESS;
    s         = cyc;
    tick();
    Key_flag  = 1'b0;
    Key_state = ~KEY_PRESS;
  endtask

  task automatic wait_tx(input string name);
    bit ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      if (Tx_en === 1'b1) begin ok = 1; break; end
    end
    if (!ok) timeout_fail(name);
  endtask

  task automatic wait_idle(input string name);
    bit ok = 0;
    repeat (2) @(posedge Clk);
    for (int i = 0; i < 200; i++) begin
      @(negedge Clk);
      if (Busy === 1'b0) begin ok = 1; break; end
    end
    if (!ok) timeout_fail(name);
    tick();
  endtask

  task automatic check_log(input string name, input int base, input logic [7:0] exp[$]);
    check({name, "_len"}, 32'(tx_log.size() - base), 32'(exp.size()));
    foreach (exp[i])
      if (base + i < tx_log.size()) check(name, 32'(tx_log[base + i]), 32'(exp[i]));
  endtask

  // ---------------- directed tests ----------------
  initial begin : p_stim
    int         s;
    int         base;
    logic [7:0] exp_q[$];

    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check("rst_tx_en", 32'(Tx_en), 32'd0);
    check("rst_tx_data", 32'(Tx_data), 32'd0);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_empty", 32'(Empty), 32'd1);
    check("rst_full", 32'(Full), 32'd0);
    check("rst_count", 32'(Count), 32'd0);
    check("rst_overflow", 32'(Overflow), 32'd0);
`ifdef UART_RING_DROP_CNT_EN
    check("rst_drop_cnt", 32'(Drop_cnt), 32'd0);
`endif
    @(posedge Clk);
    #1 Rst = 1'b0;
    tick();

    // 1: drain dump with latency pinning
    rx(8'h11); rx(8'h22); rx(8'h33);
    check("t1_count_pre", 32'(Count), 32'd3);
    base = tx_log.size();
    key(1'b0, s);
    wait_idle("t1_idle");
    exp_q = '{8'h11, 8'h22, 8'h33};
    check_log("t1_data", base, exp_q);
    if (tx_cyc.size() >= base + 3) begin
      check("t1_lat0", 32'(tx_cyc[base]), 32'(s + 3));
      check("t1_lat1", 32'(tx_cyc[base + 1]), 32'(s + 10));
      check("t1_lat2", 32'(tx_cyc[base + 2]), 32'(s + 17));
    end
    check("t1_count_post", 32'(Count), 32'd0);
    check("t1_empty_post", 32'(Empty), 32'd1);

    // 2: replay twice, buffer preserved, then drain it
    rx(8'h11); rx(8'h22); rx(8'h33);
    base = tx_log.size();
    key(1'b1, s); wait_idle("t2_idle_a");
    key(1'b1, s); wait_idle("t2_idle_b");
    exp_q = '{8'h11, 8'h22, 8'h33, 8'h11, 8'h22, 8'h33};
    check_log("t2_data", base, exp_q);
    check("t2_count", 32'(Count), 32'd3);
    key(1'b0, s); wait_idle("t2_idle_c");
    check("t2_count_drained", 32'(Count), 32'd0);

    // 3: overflow on a full buffer
    rx(8'h01); rx(8'h02); rx(8'h03); rx(8'h04); rx(8'h05);
    check("t3_full", 32'(Full), 32'd1);
    check("t3_count", 32'(Count), 32'd4);
    check("t3_overflow", 32'(Overflow), 32'd1);
`ifdef UART_RING_DROP_CNT_EN
    check("t3_drop_cnt", 32'(Drop_cnt), 32'd1);
`endif
    base = tx_log.size();
    key(1'b0, s);
    check("t3_overflow_cleared", 32'(Overflow), 32'd0);
`ifdef UART_RING_DROP_CNT_EN
    check("t3_drop_cnt_cleared", 32'(Drop_cnt), 32'd0);
`endif
    wait_idle("t3_idle");
    exp_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    check_log("t3_data", base, exp_q);

    // 4: byte arriving mid-dump stays for the next dump
    rx(8'h44); rx(8'h55);
    base = tx_log.size();
    key(1'b0, s);
    wait_tx("t4_tx");
    tick();
    rx(8'hAA);
    wait_idle("t4_idle_a");
    exp_q = '{8'h44, 8'h55};
    check_log("t4_data_a", base, exp_q);
    check("t4_count", 32'(Count), 32'd1);
    base = tx_log.size();
    key(1'b0, s); wait_idle("t4_idle_b");
    exp_q = '{8'hAA};
    check_log("t4_data_b", base, exp_q);

    // 5: key on empty buffer, key while busy, release event
    base = tx_log.size();
    key(1'b0, s);
    repeat (10) tick();
    check("t5_empty_no_tx", 32'(tx_log.size()), 32'(base));
    check("t5_empty_busy", 32'(Busy), 32'd0);
    rx(8'h61); rx(8'h62); rx(8'h63);
    key(1'b1, s);
    tick();
    key(1'b0, s);
    wait_idle("t5_idle");
    exp_q = '{8'h61, 8'h62, 8'h63};
    check_log("t5_busy_key", base, exp_q);
    check("t5_count", 32'(Count), 32'd3);
    base = tx_log.size();
    Key_flag = 1'b1; Key_state = ~KEY_PRESS;
    tick();
    Key_flag = 1'b0;
    repeat (6) tick();
    check("t5_release_no_tx", 32'(tx_log.size()), 32'(base));
    check("t5_release_busy", 32'(Busy), 32'd0);

    // 6: reset in WTX, late Tx_done ignored
    key(1'b0, s);
    wait_tx("t6_tx");
    @(posedge Clk);
    #2 Rst = 1'b1;
    @(negedge Clk);
    check("t6_rst_tx_en", 32'(Tx_en), 32'd0);
    check("t6_rst_tx_data", 32'(Tx_data), 32'd0);
    check("t6_rst_busy", 32'(Busy), 32'd0);
    check("t6_rst_empty", 32'(Empty), 32'd1);
    check("t6_rst_full", 32'(Full), 32'd0);
    check("t6_rst_count", 32'(Count), 32'd0);
    check("t6_rst_overflow", 32'(Overflow), 32'd0);
    @(posedge Clk);
    @(posedge Clk);
    #1 Rst = 1'b0;
    base = tx_log.size();
    repeat (20) tick();
    check("t6_no_tx", 32'(tx_log.size()), 32'(base));
    check("t6_busy", 32'(Busy), 32'd0);
    check("t6_count", 32'(Count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
